// File: rtl/xphy_training_master.sv
// Command-driven initiator for the 10GBASE-R PHY training port: issues one IPIF/DRP
// access per host command, waits for the matching ack or a timeout, and returns a response.
module xphy_training_master #(
    parameter logic [15:0] C_TIMEOUT      = 16'd1000,
    parameter logic [15:0] C_TIMEOUT_DATA = 16'hFFFF
) (
    input  logic        clk156,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rnw,
    input  logic        cmd_drp,
    input  logic [20:0] cmd_addr,
    input  logic [15:0] cmd_wrdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rddata,
    output logic        rsp_timeout,
    output logic        training_enable,
    output logic [20:0] training_addr,
    output logic        training_rnw,
    output logic [15:0] training_wrdata,
    output logic        training_ipif_cs,
    output logic        training_drp_cs,
    input  logic [15:0] training_rddata,
    input  logic        training_rdack,
    input  logic        training_wrack
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [15:0] LAST_WAIT = C_TIMEOUT - 16'd1;

    state_t      state_q;
    logic [15:0] cnt_q;
    logic        rnw_q;
    logic        cmd_ready_q;
    logic        rsp_valid_q;
    logic [15:0] rsp_rddata_q;
    logic        rsp_timeout_q;
    logic        enable_q;
    logic [20:0] addr_q;
    logic        trn_rnw_q;
    logic [15:0] wrdata_q;
    logic        ipif_cs_q;
    logic        drp_cs_q;
    logic        ack_hit;

    // Only the ack type matching the outstanding access completes it.
    assign ack_hit = rnw_q ? training_rdack : training_wrack;

    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            rnw_q         <= 1'b1;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rddata_q  <= '0;
            rsp_timeout_q <= 1'b0;
            enable_q      <= 1'b0;
            addr_q        <= '0;
            trn_rnw_q     <= 1'b1;
            wrdata_q      <= '0;
            ipif_cs_q     <= 1'b0;
            drp_cs_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        state_q     <= ST_ISSUE;
                        cmd_ready_q <= 1'b0;
                        rnw_q       <= cmd_rnw;
                        enable_q    <= 1'b1;
                        addr_q      <= cmd_addr;
                        trn_rnw_q   <= cmd_rnw;
                        wrdata_q    <= cmd_wrdata;
                        ipif_cs_q   <= ~cmd_drp;
                        drp_cs_q    <= cmd_drp;
                    end
                end
                ST_ISSUE: begin
                    state_q   <= ST_WAIT;
                    ipif_cs_q <= 1'b0;
                    drp_cs_q  <= 1'b0;
                    cnt_q     <= '0;
                end
                ST_WAIT: begin
                    if (ack_hit || (cnt_q == LAST_WAIT)) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        enable_q    <= 1'b0;
                        addr_q      <= '0;
                        trn_rnw_q   <= 1'b1;
                        wrdata_q    <= '0;
                        // Ack takes priority over a timeout landing in the same cycle.
                        if (ack_hit) begin
                            rsp_rddata_q  <= rnw_q ? training_rddata : '0;
                            rsp_timeout_q <= 1'b0;
                        end else begin
                            rsp_rddata_q  <= C_TIMEOUT_DATA;
                            rsp_timeout_q <= 1'b1;
                        end
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready        = cmd_ready_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_rddata       = rsp_rddata_q;
    assign rsp_timeout      = rsp_timeout_q;
    assign training_enable  = enable_q;
    assign training_addr    = addr_q;
    assign training_rnw     = trn_rnw_q;
    assign training_wrdata  = wrdata_q;
    assign training_ipif_cs = ipif_cs_q;
    assign training_drp_cs  = drp_cs_q;

endmodule

// File: tb/tb_xphy_training_master.sv
// Directed self-checking bench for xphy_training_master (C_TIMEOUT=4).
module tb_xphy_training_master;

    logic        clk156 = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rnw;
    logic        cmd_drp;
    logic [20:0] cmd_addr;
    logic [15:0] cmd_wrdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rddata;
    logic        rsp_timeout;
    logic        training_enable;
    logic [20:0] training_addr;
    logic        training_rnw;
    logic [15:0] training_wrdata;
    logic        training_ipif_cs;
    logic        training_drp_cs;
    logic [15:0] training_rddata;
    logic        training_rdack;
    logic        training_wrack;

    int n_checks = 0;
    int n_fail   = 0;
    int n_ipif   = 0;
    int n_drp    = 0;
    int n_en     = 0;

    xphy_training_master #(
        .C_TIMEOUT      (16'd4),
        .C_TIMEOUT_DATA (16'hFFFF)
    ) dut (
        .clk156           (clk156),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_rnw          (cmd_rnw),
        .cmd_drp          (cmd_drp),
        .cmd_addr         (cmd_addr),
        .cmd_wrdata       (cmd_wrdata),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_rddata       (rsp_rddata),
        .rsp_timeout      (rsp_timeout),
        .training_enable  (training_enable),
        .training_addr    (training_addr),
        .training_rnw     (training_rnw),
        .training_wrdata  (training_wrdata),
        .training_ipif_cs (training_ipif_cs),
        .training_drp_cs  (training_drp_cs),
        .training_rddata  (training_rddata),
        .training_rdack   (training_rdack),
        .training_wrack   (training_wrack)
    );

    always #5 clk156 = ~clk156;

    // Strobe/enable occupancy, sampled mid-cycle.
    always @(negedge clk156) begin
        if (training_ipif_cs === 1'b1) n_ipif++;
        if (training_drp_cs === 1'b1) n_drp++;
        if (training_enable === 1'b1) n_en++;
    end

    task automatic step();
        @(posedge clk156);
        #1;
    endtask

    task automatic drive_cmd(input logic rnw, input logic drp, input logic [20:0] a, input logic [15:0] d);
        cmd_valid  = 1'b1;
        cmd_rnw    = rnw;
        cmd_drp    = drp;
        cmd_addr   = a;
        cmd_wrdata = d;
        step();
        cmd_valid  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_drp = 1'b0; cmd_addr = '0; cmd_wrdata = '0;
        rsp_ready = 1'b0; training_rddata = '0; training_rdack = 1'b0; training_wrack = 1'b0;
        #2;
        n_checks++; if (training_enable !== 1'b0) begin n_fail++; $display("FAIL rst_enable got=%b exp=0", training_enable); end
        n_checks++; if (training_rnw !== 1'b1) begin n_fail++; $display("FAIL rst_rnw got=%b exp=1", training_rnw); end
        n_checks++; if (training_addr !== 21'h0 || training_wrdata !== 16'h0) begin n_fail++; $display("FAIL rst_fields got addr=%h wr=%h exp 0/0", training_addr, training_wrdata); end
        n_checks++; if ({training_ipif_cs, training_drp_cs} !== 2'b00) begin n_fail++; $display("FAIL rst_cs got=%b%b exp=00", training_ipif_cs, training_drp_cs); end
        n_checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_hs got rdy=%b vld=%b exp 1/0", cmd_ready, rsp_valid); end
        n_checks++; if (rsp_rddata !== 16'h0 || rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL rst_rsp got data=%h to=%b exp 0000/0", rsp_rddata, rsp_timeout); end
        step(); step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_read_ipif();
        int ipif0, drp0;
        ipif0 = n_ipif; drp0 = n_drp;
        drive_cmd(1'b1, 1'b0, 21'h01_0000, 16'h0000);
        n_checks++; if (training_ipif_cs !== 1'b1 || training_drp_cs !== 1'b0) begin n_fail++; $display("FAIL rd_issue_cs got=%b%b exp=10", training_ipif_cs, training_drp_cs); end
        n_checks++; if (training_enable !== 1'b1 || training_rnw !== 1'b1 || training_addr !== 21'h01_0000) begin n_fail++; $display("FAIL rd_issue_fields got en=%b rnw=%b addr=%h", training_enable, training_rnw, training_addr); end
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rd_issue_ready got=%b exp=0", cmd_ready); end
        step();
        n_checks++; if (training_ipif_cs !== 1'b0 || training_enable !== 1'b1 || training_addr !== 21'h01_0000) begin n_fail++; $display("FAIL rd_wait1 got cs=%b en=%b addr=%h", training_ipif_cs, training_enable, training_addr); end
        step();
        step();
        training_rdack = 1'b1; training_rddata = 16'h1234;
        step();
        training_rdack = 1'b0; training_rddata = 16'h0000;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rddata !== 16'h1234 || rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL rd_rsp got vld=%b data=%h to=%b exp 1/1234/0", rsp_valid, rsp_rddata, rsp_timeout); end
        n_checks++; if (training_enable !== 1'b0 || training_rnw !== 1'b1 || training_addr !== 21'h0 || training_wrdata !== 16'h0) begin n_fail++; $display("FAIL rd_tieoff got en=%b rnw=%b addr=%h wr=%h", training_enable, training_rnw, training_addr, training_wrdata); end
        n_checks++; if (n_ipif - ipif0 !== 1 || n_drp - drp0 !== 0) begin n_fail++; $display("FAIL rd_strobes got ipif=%0d drp=%0d exp 1/0", n_ipif - ipif0, n_drp - drp0); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rd_done got vld=%b rdy=%b exp 0/1", rsp_valid, cmd_ready); end
    endtask

    task automatic test_write_drp();
        training_rddata = 16'hDEAD;
        drive_cmd(1'b0, 1'b1, 21'h00_0045, 16'hA5A5);
        n_checks++; if (training_drp_cs !== 1'b1 || training_ipif_cs !== 1'b0) begin n_fail++; $display("FAIL wr_issue_cs got drp=%b ipif=%b exp 1/0", training_drp_cs, training_ipif_cs); end
        n_checks++; if (training_rnw !== 1'b0 || training_wrdata !== 16'hA5A5 || training_addr !== 21'h00_0045) begin n_fail++; $display("FAIL wr_issue_fields got rnw=%b wr=%h addr=%h", training_rnw, training_wrdata, training_addr); end
        step();
        training_wrack = 1'b1;
        step();
        training_wrack = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rddata !== 16'h0000 || rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL wr_rsp got vld=%b data=%h to=%b exp 1/0000/0", rsp_valid, rsp_rddata, rsp_timeout); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        training_rddata = 16'h0000;
    endtask

    task automatic test_timeout();
        int en0;
        en0 = n_en;
        drive_cmd(1'b1, 1'b0, 21'h00_1000, 16'h0000);
        step(); step(); step(); step();
        n_checks++; if (rsp_valid !== 1'b0 || training_enable !== 1'b1) begin n_fail++; $display("FAIL to_last_wait got vld=%b en=%b exp 0/1", rsp_valid, training_enable); end
        step();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_rddata !== 16'hFFFF) begin n_fail++; $display("FAIL to_rsp got vld=%b to=%b data=%h exp 1/1/ffff", rsp_valid, rsp_timeout, rsp_rddata); end
        n_checks++; if (n_en - en0 !== 5) begin n_fail++; $display("FAIL to_enable_cycles got=%0d exp=5", n_en - en0); end
        training_rdack = 1'b1; training_rddata = 16'h1111;
        step();
        training_rdack = 1'b0;
        n_checks++; if (rsp_rddata !== 16'hFFFF || rsp_timeout !== 1'b1) begin n_fail++; $display("FAIL to_late_ack got data=%h to=%b exp ffff/1", rsp_rddata, rsp_timeout); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        training_rdack = 1'b1;
        step();
        training_rdack = 1'b0;
        step();
        n_checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || training_enable !== 1'b0) begin n_fail++; $display("FAIL to_idle_ack got vld=%b rdy=%b en=%b exp 0/1/0", rsp_valid, cmd_ready, training_enable); end
        training_rddata = 16'h0000;
    endtask

    task automatic test_boundary_acks();
        drive_cmd(1'b1, 1'b0, 21'h00_0200, 16'h0000);
        step();
        training_wrack = 1'b1;
        step();
        training_wrack = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0 || training_enable !== 1'b1) begin n_fail++; $display("FAIL bnd_wrong_ack got vld=%b en=%b exp 0/1", rsp_valid, training_enable); end
        step(); step();
        training_rdack = 1'b1; training_rddata = 16'hBEEF;
        step();
        training_rdack = 1'b0; training_rddata = 16'h0000;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0 || rsp_rddata !== 16'hBEEF) begin n_fail++; $display("FAIL bnd_last_ack got vld=%b to=%b data=%h exp 1/0/beef", rsp_valid, rsp_timeout, rsp_rddata); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_pressure();
        int bad;
        int en0;
        bad = 0;
        drive_cmd(1'b1, 1'b1, 21'h00_0077, 16'h0000);
        step();
        training_rdack = 1'b1; training_rddata = 16'h5A5A;
        step();
        training_rdack = 1'b0; training_rddata = 16'h0000;
        cmd_valid = 1'b1; cmd_rnw = 1'b0; cmd_drp = 1'b0; cmd_addr = 21'h1F_FFFF; cmd_wrdata = 16'h7777;
        en0 = n_en;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid !== 1'b1 || rsp_rddata !== 16'h5A5A || rsp_timeout !== 1'b0 || cmd_ready !== 1'b0) bad++;
            step();
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_hold got bad_cycles=%0d exp=0", bad); end
        n_checks++; if (n_en - en0 !== 0) begin n_fail++; $display("FAIL bp_no_accept got enable_cycles=%0d exp=0", n_en - en0); end
        rsp_ready = 1'b1;
        step();
        cmd_valid = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got vld=%b rdy=%b exp 0/1", rsp_valid, cmd_ready); end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (rsp_valid !== 1'b0) bad++;
        end
        rsp_ready = 1'b0;
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_single_rsp got extra=%0d exp=0", bad); end
    endtask

    task automatic test_reset_in_wait();
        int bad;
        bad = 0;
        drive_cmd(1'b0, 1'b0, 21'h00_0ABC, 16'h3C3C);
        step();
        reset = 1'b1;
        #1;
        n_checks++; if (training_enable !== 1'b0 || training_rnw !== 1'b1 || training_addr !== 21'h0 || training_wrdata !== 16'h0) begin n_fail++; $display("FAIL rw_bus got en=%b rnw=%b addr=%h wr=%h", training_enable, training_rnw, training_addr, training_wrdata); end
        n_checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || {training_ipif_cs, training_drp_cs} !== 2'b00) begin n_fail++; $display("FAIL rw_hs got rdy=%b vld=%b cs=%b%b", cmd_ready, rsp_valid, training_ipif_cs, training_drp_cs); end
        step(); step();
        reset = 1'b0;
        training_wrack = 1'b1;
        step();
        training_wrack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid !== 1'b0) bad++;
            step();
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rw_no_rsp got rsp_cycles=%0d exp=0", bad); end
        drive_cmd(1'b1, 1'b0, 21'h00_0321, 16'h0000);
        step();
        step();
        training_rdack = 1'b1; training_rddata = 16'h0F0F;
        step();
        training_rdack = 1'b0; training_rddata = 16'h0000;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rddata !== 16'h0F0F || rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL rw_after got vld=%b data=%h to=%b exp 1/0f0f/0", rsp_valid, rsp_rddata, rsp_timeout); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read_ipif();
        test_write_drp();
        test_timeout();
        test_boundary_acks();
        test_back_pressure();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xphy_training_master.md
# xphy_training_master

Command-driven initiator for the 10GBASE-R PHY core training interface. Replaces the constant tie-off of the training bus (enable=0, rnw=1, selects=0) with a sequencer that issues single IPIF or DRP register reads/writes on host request. It waits for the core's rdack/wrack and returns read data or a timeout indication. Sits beside the PHY glue in the clk156 domain, between a host register block and the core's training port.

## Interface
- C_TIMEOUT, 16'd1000: WAIT-state cycles allowed before abort; legal range 2..65535.
- C_TIMEOUT_DATA, 16'hFFFF: rsp_rddata value returned on timeout.
- clk156  in  1  core clock; all logic is in this domain.
- reset  in  1  asynchronous, active-high.
- cmd_valid  in  1  host command request.
- cmd_ready  out  1  block can accept a command.
- cmd_rnw  in  1  1 = read, 0 = write.
- cmd_drp  in  1  1 = DRP target (drp_cs), 0 = IPIF/MDIO register target (ipif_cs).
- cmd_addr  in  21  register address.
- cmd_wrdata  in  16  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  host accepts response.
- rsp_rddata  out  16  read data (writes return 0; timeout returns C_TIMEOUT_DATA).
- rsp_timeout  out  1  access aborted without ack.
- training_enable  out  1  training bus ownership.
- training_addr  out  21, training_rnw  out  1, training_wrdata  out  16  access fields.
- training_ipif_cs  out  1, training_drp_cs  out  1  one-cycle select strobes.
- training_rddata  in  16, training_rdack  in  1, training_wrack  in  1  core responses.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: cmd_ready=1. cmd_valid&cmd_ready latches rnw/drp/addr/wrdata and moves to ISSUE.
- ISSUE, exactly one cycle:
  - training_enable=1.
  - addr/rnw/wrdata driven from the latch.
  - Exactly one select high: drp_cs if cmd_drp, else ipif_cs.
  - Timeout counter cleared. Go to WAIT.
- WAIT:
  - training_enable stays 1, selects 0, fields held.
  - Counter increments each cycle.
  - Matching ack (rdack if rnw, wrack if !rnw) captures the response: rsp_rddata = training_rddata for reads, 0 for writes; rsp_timeout=0. Go to RESP.
  - Otherwise, when counter == C_TIMEOUT-1: rsp_rddata = C_TIMEOUT_DATA, rsp_timeout=1. Go to RESP.
  - Ack and timeout in the same cycle: ack wins.
  - Non-matching ack is ignored.
- RESP:
  - training_enable=0, training_rnw=1, training_addr=0, training_wrdata=0.
  - rsp_valid=1. rsp_rddata and rsp_timeout are held stable until rsp_ready.
  - rsp_valid&rsp_ready returns to IDLE.
- Acks arriving in IDLE, ISSUE or RESP are ignored.
- cmd_ready=0 in ISSUE, WAIT and RESP. Only one access is outstanding at a time; no queuing.
- Counter is 16 bits, saturating, never wraps.

## Timing
- All outputs are registered. Reset values are the tie-off values:
  - training_enable=0, training_rnw=1, training_addr=0, training_wrdata=0, both selects 0.
  - cmd_ready=1, rsp_valid=0, rsp_rddata=0, rsp_timeout=0.
- Command accepted at edge N: selects high in cycle N+1 only; training_enable high from N+1 until the edge that enters RESP.
- Ack sampled high at edge M: rsp_valid high from M+1. Minimum command-to-response is 3 cycles with an ack in the first WAIT cycle.
- Timeout: the ack window is exactly C_TIMEOUT WAIT cycles. rsp_valid rises the cycle after the last WAIT cycle.
- Next command can be accepted the cycle after the rsp handshake (one IDLE cycle minimum).
- Reset asserted in any state: all outputs return asynchronously to reset values. The pending command and response are discarded; no response is produced for them.

## Test plan
- Read IPIF: cmd addr=21'h01_0000, rnw=1, drp=0. Responder returns rdack with data 16'h1234 three cycles after the strobe. Required: ipif_cs high exactly one cycle, drp_cs never high; rsp_rddata=16'h1234, rsp_timeout=0; bus returns to tie-off values.
- Write DRP: addr=21'h00_0045, wrdata=16'hA5A5, drp=1. wrack after one cycle. Required: drp_cs strobe with training_rnw=0 and wrdata=16'hA5A5 in the same cycle; rsp_rddata=0, rsp_timeout=0.
- Timeout with C_TIMEOUT=4, no ack: training_enable high for exactly 5 cycles (ISSUE + 4 WAIT); rsp_timeout=1, rsp_rddata=16'hFFFF. A late rdack after that is ignored.
- Wrong and boundary acks on a read: wrack in WAIT is ignored. rdack coinciding with the last timeout cycle gives rsp_timeout=0 and captured data.
- Back-pressure: hold rsp_ready=0 for 10 cycles. Required: rsp_valid and data held stable, cmd_ready=0, a new cmd_valid is not accepted; release gives one response only.
- Reset during WAIT: all outputs return to reset values immediately; after release, a new read completes normally.
